fft_bfly_writeback: RTL and testbench

- Write-back counterpart of the burst FFT read-side pairing stage.
- Takes butterfly results (a, b, address index) and issues in-place writes to the two-bank (A/B) working RAM.
- First level: direct pass-through. Later levels: undoes the cross-beat pairing, so bank A/B layout matches what the read side expects on the next level.
- Sits between the butterfly core output and the bank-A/B RAM write ports. No backpressure.

---
 rtl/fft_bfly_writeback.sv | 171 +++++++++++++++++
 tb/tb_fft_bfly_writeback.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_writeback.sv
// In-place write-back of butterfly results into the two-bank (A/B) FFT working RAM.
// Optional build macro FFT_WB_SCALE_EN: halve every re/im component (round-half-up, saturating).
module fft_bfly_writeback #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic                  in_last,
    input  logic                  first_lev,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  err_clr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data_a,
    output logic [DATA_WIDTH-1:0] wr_data_b,
    output logic                  level_done,
    output logic                  pair_err,
    output logic                  busy
);

    localparam int HW = DATA_WIDTH / 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  last;
    } wr_item_t;

    // Held even beat (parity is odd exactly while this is valid)
    logic                  hold_vld_reg;
    logic [ADDR_WIDTH-1:0] hold_addr_reg;
    logic [DATA_WIDTH-1:0] hold_a_reg;
    logic [DATA_WIDTH-1:0] hold_b_reg;

    logic                  pend_vld_reg;
    wr_item_t              pend_reg;

    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_a_reg;
    logic [DATA_WIDTH-1:0] wr_data_b_reg;
    logic                  wr_last_reg;
    logic                  level_done_reg;
    logic                  pair_err_reg;
    logic                  busy_reg;

    logic                  beat_lev;
    logic                  beat_first;
    logic                  pair_now;
    logic                  orphan_new;
    logic                  load_hold;
    logic                  err_set;
    wr_item_t              cand [4];
    logic [3:0]            cand_vld;
    wr_item_t              sel0_next;
    wr_item_t              sel1_next;
    logic                  sel0_vld_next;
    logic                  sel1_vld_next;
    logic [DATA_WIDTH-1:0] data_a_next;
    logic [DATA_WIDTH-1:0] data_b_next;

    // Candidate writes in issue order: pending, write1/flush of hold, write2, new beat.
    // At most two are ever valid together; the first is written now, the second is deferred.
    always_comb begin
        beat_lev   = in_vld & ~first_lev;
        beat_first = in_vld & first_lev;
        pair_now   = hold_vld_reg & beat_lev;
        orphan_new = beat_lev & ~hold_vld_reg & in_last;
        load_hold  = beat_lev & ~hold_vld_reg & ~in_last;
        err_set    = (hold_vld_reg & ~beat_lev) | orphan_new;

        cand[0]     = pend_reg;
        cand_vld[0] = pend_vld_reg;
        cand[1]     = pair_now ? '{hold_addr_reg, hold_a_reg, in_a, 1'b0}
                               : '{hold_addr_reg, hold_a_reg, hold_b_reg, 1'b0};
        cand_vld[1] = hold_vld_reg;
        cand[2]     = '{in_addr, hold_b_reg, in_b, in_last};
        cand_vld[2] = pair_now;
        cand[3]     = '{in_addr, in_a, in_b, in_last};
        cand_vld[3] = beat_first | orphan_new;

        sel0_next     = '0;
        sel1_next     = '0;
        sel0_vld_next = 1'b0;
        sel1_vld_next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cand_vld[i]) begin
                if (!sel0_vld_next) begin
                    sel0_next     = cand[i];
                    sel0_vld_next = 1'b1;
                end else if (!sel1_vld_next) begin
                    sel1_next     = cand[i];
                    sel1_vld_next = 1'b1;
                end
            end
        end
    end

`ifdef FFT_WB_SCALE_EN
    function automatic logic [HW-1:0] scale_half(input logic [HW-1:0] x);
        logic [HW:0] sum;
        sum = {x[HW-1], x[HW-1], x[HW-1:1]} + {{HW{1'b0}}, x[0]};
        if (sum[HW] != sum[HW-1]) begin
            return {1'b0, {(HW-1){1'b1}}};
        end
        return sum[HW-1:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_scale
            assign data_a_next[gi*HW +: HW] = scale_half(sel0_next.a[gi*HW +: HW]);
            assign data_b_next[gi*HW +: HW] = scale_half(sel0_next.b[gi*HW +: HW]);
        end
    endgenerate
`else
    assign data_a_next = sel0_next.a;
    assign data_b_next = sel0_next.b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_reg   <= 1'b0;
            hold_addr_reg  <= '0;
            hold_a_reg     <= '0;
            hold_b_reg     <= '0;
            pend_vld_reg   <= 1'b0;
            pend_reg       <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_a_reg  <= '0;
            wr_data_b_reg  <= '0;
            wr_last_reg    <= 1'b0;
            level_done_reg <= 1'b0;
            pair_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            hold_vld_reg <= load_hold;
            if (load_hold) begin
                hold_addr_reg <= in_addr;
                hold_a_reg    <= in_a;
                hold_b_reg    <= in_b;
            end
            pend_vld_reg   <= sel1_vld_next;
            pend_reg       <= sel1_next;
            wr_en_reg      <= sel0_vld_next;
            wr_addr_reg    <= sel0_next.addr;
            wr_data_a_reg  <= data_a_next;
            wr_data_b_reg  <= data_b_next;
            wr_last_reg    <= sel0_vld_next & sel0_next.last;
            level_done_reg <= wr_last_reg;
            // Set wins over clear
            pair_err_reg   <= err_set | (pair_err_reg & ~err_clr);
            busy_reg       <= load_hold | sel1_vld_next | sel0_vld_next | wr_last_reg;
        end
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data_a  = wr_data_a_reg;
    assign wr_data_b  = wr_data_b_reg;
    assign level_done = level_done_reg;
    assign pair_err   = pair_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_fft_bfly_writeback.sv
// Bench for fft_bfly_writeback: directed steps plus random levels against a write-queue reference model.
module tb_fft_bfly_writeback;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_last = 1'b0;
    logic          first_lev = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          err_clr = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data_a;
    logic [DW-1:0] wr_data_b;
    logic          level_done;
    logic          pair_err;
    logic          busy;

    always #5 clk = ~clk;

    fft_bfly_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_last(in_last),
        .first_lev(first_lev), .in_addr(in_addr), .in_a(in_a), .in_b(in_b),
        .err_clr(err_clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .level_done(level_done),
        .pair_err(pair_err), .busy(busy)
    );

    // Reference: every edge appends the RAM writes the rules produce, and the RAM port drains one per cycle.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit            last;
    } wr_t;

    wr_t           q[$];
    bit            m_held;
    logic [AW-1:0] m_h_addr;
    logic [DW-1:0] m_h_a;
    logic [DW-1:0] m_h_b;
    bit            e_wr_en, e_done, e_err, e_busy, e_wlast;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_da, e_db;
    int            checks = 0;
    int            errors = 0;

`ifdef FFT_WB_SCALE_EN
    function automatic logic [15:0] half_scale(input logic [15:0] h);
        int v;
        v = int'($signed(h));
        v = (v + 1) >>> 1;
        if (v > 32767) v = 32767;
        return v[15:0];
    endfunction
`endif

    function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] d);
`ifdef FFT_WB_SCALE_EN
        return {half_scale(d[31:16]), half_scale(d[15:0])};
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_held = 0; m_h_addr = '0; m_h_a = '0; m_h_b = '0;
        e_wr_en = 0; e_done = 0; e_err = 0; e_busy = 0; e_wlast = 0;
        e_addr = '0; e_da = '0; e_db = '0;
    endtask

    task automatic model_edge();
        wr_t w;
        bit  err_set;
        err_set = 0;
        e_done  = e_wlast;
        if (m_held) begin
            if (in_vld && !first_lev) begin
                q.push_back('{m_h_addr, m_h_a, in_a, 1'b0});
                q.push_back('{in_addr, m_h_b, in_b, in_last});
            end else begin
                q.push_back('{m_h_addr, m_h_a, m_h_b, 1'b0});
                err_set = 1;
                if (in_vld) q.push_back('{in_addr, in_a, in_b, in_last});
            end
            m_held = 0;
        end else if (in_vld) begin
            if (first_lev) begin
                q.push_back('{in_addr, in_a, in_b, in_last});
            end else if (in_last) begin
                q.push_back('{in_addr, in_a, in_b, 1'b1});
                err_set = 1;
            end else begin
                m_held = 1; m_h_addr = in_addr; m_h_a = in_a; m_h_b = in_b;
            end
        end
        if (err_set) e_err = 1;
        else if (err_clr) e_err = 0;
        if (q.size() > 0) begin
            w = q.pop_front();
            e_wr_en = 1; e_addr = w.addr; e_da = exp_data(w.a); e_db = exp_data(w.b); e_wlast = w.last;
        end else begin
            e_wr_en = 0; e_wlast = 0;
        end
        e_busy = m_held || (q.size() != 0) || e_wr_en || e_done;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("wr_en", 64'(wr_en), 64'(e_wr_en));
        chk("level_done", 64'(level_done), 64'(e_done));
        chk("pair_err", 64'(pair_err), 64'(e_err));
        chk("busy", 64'(busy), 64'(e_busy));
        if (e_wr_en) begin
            chk("wr_addr", 64'(wr_addr), 64'(e_addr));
            chk("wr_data_a", 64'(wr_data_a), 64'(e_da));
            chk("wr_data_b", 64'(wr_data_b), 64'(e_db));
        end
        $display("cyc t=%0t vld=%0b first=%0b last=%0b addr=%0h | wr_en=%0b wr_addr=%0h a=%0h b=%0h done=%0b err=%0b busy=%0b",
                 $time, in_vld, first_lev, in_last, in_addr, wr_en, wr_addr, wr_data_a, wr_data_b,
                 level_done, pair_err, busy);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic beat(input bit f, input bit l, input logic [AW-1:0] ad,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_vld = 1; first_lev = f; in_last = l; in_addr = ad; in_a = a; in_b = b;
        cycle();
        in_vld = 0; in_last = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_vld = 0; in_last = 0;
            cycle();
        end
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1;

        // First level: direct pass-through, level_done after the 4th write
        for (int k = 0; k < 4; k++)
            beat(1, k == 3, AW'(k), 32'h0001_0000 + DW'(k), 32'h0002_0000 + DW'(k));
        idle(2);

        // One pair E(4)/O(5)
        beat(0, 0, 10'd4, $urandom, $urandom);
        beat(0, 0, 10'd5, $urandom, $urandom);
        idle(2);

        // Eight continuous beats, in_last on the eighth
        for (int k = 0; k < 8; k++)
            beat(0, k == 7, AW'(16 + k), $urandom, $urandom);
        idle(3);
        chk("busy_after_level", 64'(busy), 64'd0);

        // Orphan via in_vld=0, then sticky error, then set-beats-clear
        beat(0, 0, 10'd9, 32'h11, 32'h22);
        idle(2);
        beat(0, 0, 10'd12, $urandom, $urandom);
        err_clr = 1;
        idle(1);
        err_clr = 0;
        chk("err_set_over_clr", 64'(pair_err), 64'd1);
        err_clr = 1;
        idle(1);
        err_clr = 0;
        idle(1);

        // Orphan via in_last on an even beat
        beat(0, 1, 10'd30, $urandom, $urandom);
        idle(3);

        // Held even beat interrupted by a first-level beat
        beat(0, 0, 10'd60, $urandom, $urandom);
        beat(1, 1, 10'd61, $urandom, $urandom);
        idle(3);

        // Asynchronous reset while write2 is pending
        beat(0, 0, 10'd50, $urandom, $urandom);
        beat(0, 0, 10'd51, $urandom, $urandom);
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        #1 rst_n = 1;
        idle(3);

        // Scaling corner
        beat(1, 1, 10'd40, 32'h0003_FFFD, 32'h0);
`ifdef FFT_WB_SCALE_EN
        chk("scale_a", 64'(wr_data_a), 64'h0002_FFFF);
`else
        chk("scale_a", 64'(wr_data_a), 64'h0003_FFFD);
`endif
        idle(2);

        // Random levels with gaps and random error clears
        for (int lv = 0; lv < 30; lv++) begin
            bit f;
            int n;
            f = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    err_clr = 1'($urandom_range(0, 1));
                    idle(1);
                    err_clr = 0;
                end
                err_clr = ($urandom_range(0, 7) == 0);
                beat(f, k == n - 1, AW'($urandom_range(0, 1023)), $urandom, $urandom);
                err_clr = 0;
            end
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
